// File: rtl/adder_pkg.sv
// Shared defaults and pipeline-depth derivation for the pipelined adder/subtractor.
package adder_pkg;

  // Operand/result width used when the top is instantiated without overrides.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Bits resolved per pipeline stage by default.
  localparam int DEFAULT_BLOCK_SIZE = 4;

  // Number of carry-chain stages; data_width must be a whole multiple of block_size.
  function automatic int num_stages(input int data_width, input int block_size);
    return data_width / block_size;
  endfunction

  // Low bit index of slice k.
  function automatic int slice_lo(input int k, input int block_size);
    return k * block_size;
  endfunction

endpackage

// File: rtl/pipelined_adder_subtractor_if.sv
// Operand/result bus of the pipelined adder/subtractor with valid/ready on both sides.
interface pipelined_adder_subtractor_if
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  // Input side: one operand beat per in_valid && in_ready.
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  Cin;
  logic                  SUB;

  // Output side: one result beat per out_valid && out_ready.
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] S;
  logic                  CF;
  logic                  OF;

  // Producer/consumer view (the bench).
  modport master (
    output in_valid, A, B, Cin, SUB, out_ready,
    input  in_ready, out_valid, S, CF, OF
  );

  // Arithmetic block view.
  modport slave (
    input  in_valid, A, B, Cin, SUB, out_ready,
    output in_ready, out_valid, S, CF, OF
  );

endinterface

// File: rtl/adder_slice.sv
// Purely combinational ripple adder for one BLOCK_SIZE-wide slice of the operands.
// cmsb is the carry into the slice MSB; together with cout it yields signed overflow
// when this is the most significant slice.
module adder_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [WIDTH:0] carry;

  // Bit-serial ripple: each bit's carry feeds the next within the same cycle.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[WIDTH];
  assign cmsb = carry[WIDTH-1];

endmodule

// File: rtl/pipelined_adder_subtractor.sv
// Carry-pipelined adder/subtractor. Stage k resolves bit slice k using the carry
// registered by stage k-1. Operands ride along in per-stage registers so the upper
// slices meet their carry (skew), and the partial result rides along so every slice
// of a beat leaves together (deskew). All stages advance on one shared enable, so
// bubbles occupy a stage just like data and beats leave in acceptance order.
module pipelined_adder_subtractor
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipelined_adder_subtractor_if.slave bus
);

  localparam int NUM_STAGES = num_stages(DATA_WIDTH, BLOCK_SIZE);

  // Pipeline advance: the last stage is empty or is being consumed this cycle.
  logic en;

  // Per-stage registers (index k holds the beat that has passed through k+1 slices).
  logic [DATA_WIDTH-1:0] a_reg     [NUM_STAGES];
  logic [DATA_WIDTH-1:0] b_reg     [NUM_STAGES];
  logic [DATA_WIDTH-1:0] s_reg     [NUM_STAGES];
  logic                  carry_reg [NUM_STAGES];
  logic                  valid_reg [NUM_STAGES];
  logic                  of_reg;

  // What each stage sees at its input: the bus for stage 0, the previous stage otherwise.
  logic [DATA_WIDTH-1:0] a_src     [NUM_STAGES];
  logic [DATA_WIDTH-1:0] b_src     [NUM_STAGES];
  logic [DATA_WIDTH-1:0] s_src     [NUM_STAGES];
  logic                  carry_src [NUM_STAGES];
  logic                  valid_src [NUM_STAGES];

  // Slice adder results for each stage.
  logic [BLOCK_SIZE-1:0] slice_sum  [NUM_STAGES];
  logic                  slice_cout [NUM_STAGES];
  logic                  slice_cmsb [NUM_STAGES];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : stage_g
      if (gi == 0) begin : head_g
        // Subtraction is A + ~B + 1: B is inverted up front and Cin is forced high,
        // so the user's Cin has no effect in subtract mode.
        assign a_src[gi]     = bus.A;
        assign b_src[gi]     = bus.B ^ {DATA_WIDTH{bus.SUB}};
        assign carry_src[gi] = bus.SUB ? 1'b1 : bus.Cin;
        assign valid_src[gi] = bus.in_valid;
        assign s_src[gi]     = '0;
      end else begin : chain_g
        assign a_src[gi]     = a_reg[gi-1];
        assign b_src[gi]     = b_reg[gi-1];
        assign carry_src[gi] = carry_reg[gi-1];
        assign valid_src[gi] = valid_reg[gi-1];
        assign s_src[gi]     = s_reg[gi-1];
      end

      adder_slice #(
        .WIDTH (BLOCK_SIZE)
      ) u_slice (
        .a    (a_src[gi][gi*BLOCK_SIZE +: BLOCK_SIZE]),
        .b    (b_src[gi][gi*BLOCK_SIZE +: BLOCK_SIZE]),
        .cin  (carry_src[gi]),
        .sum  (slice_sum[gi]),
        .cout (slice_cout[gi]),
        .cmsb (slice_cmsb[gi])
      );
    end
  endgenerate

  assign en = !valid_reg[NUM_STAGES-1] || bus.out_ready;

  // Stage registers: reset empties the pipe and zeroes results; otherwise every stage
  // (valid bit included) shifts forward together whenever the pipe may advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        carry_reg[k] <= 1'b0;
        s_reg[k]     <= '0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
      end
      of_reg <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_reg[k] <= valid_src[k];
        carry_reg[k] <= slice_cout[k];
        a_reg[k]     <= a_src[k];
        b_reg[k]     <= b_src[k];
        // Carry the lower result slices forward and drop this stage's slice in place.
        s_reg[k]                                 <= s_src[k];
        s_reg[k][slice_lo(k, BLOCK_SIZE) +: BLOCK_SIZE] <= slice_sum[k];
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      of_reg <= slice_cmsb[NUM_STAGES-1] ^ slice_cout[NUM_STAGES-1];
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = valid_reg[NUM_STAGES-1];
  assign bus.S         = s_reg[NUM_STAGES-1];
  assign bus.CF        = carry_reg[NUM_STAGES-1];
  assign bus.OF        = of_reg;

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Directed bench for the 8-bit, 4-bit-slice (two-stage) adder/subtractor.
module tb_pipelined_adder_subtractor;

  logic clk;
  logic rst_n;

  pipelined_adder_subtractor_if #(.DATA_WIDTH(8)) bus ();

  pipelined_adder_subtractor #(
    .DATA_WIDTH (8),
    .BLOCK_SIZE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         n_out    = 0;
  logic [9:0] exp_q [$];
  logic [9:0] cur_exp;
  logic [9:0] got;
  bit         acc;
  int         tries;
  logic [7:0] bv;
  logic [7:0] b_tab [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something waits forever.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: {OF, CF, S} of A + (B ^ {8{SUB}}) + (SUB ? 1 : Cin).
  function automatic logic [9:0] ref_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
    logic [7:0] be;
    logic [8:0] r;
    logic       of;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + 9'(sub ? 1'b1 : cin);
    of = (a[7] == be[7]) && (r[7] != a[7]);
    return {of, r[8], r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with the current inputs: score consumption and acceptance, then advance.
  task automatic cycle_io(output bit accepted);
    #1;
    accepted = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_beat observed=0x%0h expected=none", {bus.OF, bus.CF, bus.S});
      end
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("stream_result", 32'({bus.OF, bus.CF, bus.S}), 32'(got));
        n_out++;
      end
    end
    if (accepted) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  // Single beat with exact two-cycle latency check and hand-computed result.
  task automatic dir_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] es, input logic ecf, input logic eof);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.SUB = sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0; bus.A = 8'hA5; bus.B = 8'h5A; bus.Cin = 1'b1; bus.SUB = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_S"},  32'(bus.S),  32'(es));
    chk({tag, "_CF"}, 32'(bus.CF), 32'(ecf));
    chk({tag, "_OF"}, 32'(bus.OF), 32'(eof));
    $display("beat %s: a=%02h b=%02h cin=%0b sub=%0b -> S=%02h CF=%0b OF=%0b",
             tag, a, b, cin, sub, bus.S, bus.CF, bus.OF);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = 8'h00; bus.B = 8'h00; bus.Cin = 1'b0; bus.SUB = 1'b0;
    cur_exp = '0;
    b_tab = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};

    // Reset state.
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_S",  32'(bus.S),  32'd0);
    chk("rst_CF", 32'(bus.CF), 32'd0);
    chk("rst_OF", 32'(bus.OF), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed arithmetic vectors.
    dir_beat("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir_beat("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    dir_beat("sub_00_01_c", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    dir_beat("sub_80_01",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    dir_beat("sub_05_05",   8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    dir_beat("add_80_80",   8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    dir_beat("add_12_34_c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    dir_beat("sub_7f_ff",   8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    dir_beat("add_0f_01",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    // Back-pressure: four beats, consumer stalls three cycles on the first result.
    n_out = 0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.A = 8'h11; bus.B = 8'h22; bus.Cin = 1'b0; bus.SUB = 1'b0; cur_exp = 10'h033;
    cycle_io(acc); chk("bp_acc0", 32'(acc), 32'd1);
    bus.A = 8'hF0; bus.B = 8'h10; bus.Cin = 1'b0; bus.SUB = 1'b0; cur_exp = 10'h100;
    cycle_io(acc); chk("bp_acc1", 32'(acc), 32'd1);
    bus.A = 8'h30; bus.B = 8'h40; bus.Cin = 1'b0; bus.SUB = 1'b1; cur_exp = 10'h0F0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_S_hold",    32'(bus.S),         32'h33);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    cycle_io(acc); chk("bp_acc2", 32'(acc), 32'd1);
    bus.A = 8'h7F; bus.B = 8'h7F; bus.Cin = 1'b1; bus.SUB = 1'b0; cur_exp = 10'h2FF;
    cycle_io(acc); chk("bp_acc3", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle_io(acc);
    chk("bp_delivered", 32'(n_out), 32'd4);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("backpressure: %0d beats delivered", n_out);

    // Streaming sweep in both modes with random consumer stalls.
    n_out = 0;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 256; a++) begin
        for (int j = 0; j < 7; j++) begin
          bv = (j == 6) ? (8'(a) ^ 8'h5A) : b_tab[j];
          bus.A = 8'(a); bus.B = bv; bus.Cin = a[0] ^ j[0]; bus.SUB = m[0];
          cur_exp = ref_fn(8'(a), bv, a[0] ^ j[0], m[0]);
          bus.in_valid = 1'b1;
          acc = 1'b0;
          tries = 0;
          while (!acc && tries < 50) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle_io(acc);
            tries++;
          end
          chk("sweep_accept", 32'(acc), 32'd1);
        end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle_io(acc);
    chk("sweep_delivered", 32'(n_out), 32'd3584);
    chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("sweep: %0d beats delivered", n_out);

    // Reset while beats are in flight: they must vanish.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.A = 8'h01; bus.B = 8'h01; bus.Cin = 1'b0; bus.SUB = 1'b0;
    tick();
    bus.A = 8'h02; bus.B = 8'h02;
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_S",  32'(bus.S),  32'd0);
    chk("midrst_CF", 32'(bus.CF), 32'd0);
    chk("midrst_OF", 32'(bus.OF), 32'd0);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    tick();
    chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
      tick();
    end
    dir_beat("post_rst_sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
